sprite_draw_scheduler: RTL and testbench
========================================

Name: sprite_draw_scheduler

Overview:
- Sequences one shared 4x4-box plotting path into the VGA adapter pixel port for NUM_SPRITES independent movers, such as the ball and the paddles.
- On each frame tick it serves every sprite that requested a redraw, one at a time:
  - erase the box at the sprite's last drawn position using background colour;
  - latch the sprite's new position and colour;
  - draw the box there;
  - acknowledge the sprite.
- Sits between the per-sprite movement logic (position/bounce) and the VGA adapter. It replaces the per-object clear/update/draw control.

Parameters:
- NUM_SPRITES, 2, number of requesters (1..8).
- BG_COLOUR, 3'b000, colour used for erase pixels.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle frame/refresh pulse from rate divider.
- req  in  NUM_SPRITES  per-sprite redraw request; level, held until ack.
- x_in  in  7*NUM_SPRITES  new x per sprite; sprite i at bits [7i+6:7i].
- y_in  in  7*NUM_SPRITES  new y per sprite, same packing.
- c_in  in  3*NUM_SPRITES  draw colour per sprite; sprite i at bits [3i+2:3i].
- vga_x  out  7  pixel x to adapter.
- vga_y  out  7  pixel y to adapter.
- vga_colour  out  3  pixel colour to adapter.
- plot  out  1  adapter write enable.
- ack  out  NUM_SPRITES  one-hot, one-cycle pulse when sprite i redraw completes.
- busy  out  1  high in any state other than IDLE.
- tick_missed  out  1  one-cycle pulse when tick arrives while busy.

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE; pending=0; offset=0; cur index=0.
  - All drawn[i]=0; old_x/old_y/col regs=0.
  - Outputs: plot=0, ack=0, busy=0, tick_missed=0, vga_x=0, vga_y=0, vga_colour=0.
  - Reset mid-operation aborts immediately. No partial box is completed.
- States: IDLE, SELECT, ERASE, LATCH, DRAW, DONE.
- IDLE:
  - On tick, pending <= req.
  - If req != 0 go to SELECT; else stay in IDLE.
  - req is ignored without a tick.
- SELECT (1 cycle):
  - Choose the lowest set index in pending as cur.
  - If drawn[cur]=1, go to ERASE; else go to LATCH.
- ERASE (16 cycles):
  - plot=1, vga_colour=BG_COLOUR.
  - vga_x=old_x[cur]+offset[1:0], vga_y=old_y[cur]+offset[3:2]; offset counts 0..15.
  - At offset=15, offset<=0 and go to LATCH.
- LATCH (1 cycle):
  - plot=0.
  - old_x[cur]<=x_in slice, old_y[cur]<=y_in slice, col[cur]<=c_in slice.
  - Go to DRAW.
  - Inputs are sampled only here; changes elsewhere have no effect.
- DRAW (16 cycles):
  - plot=1, vga_colour=col[cur].
  - Coordinates computed as in ERASE but from the newly latched regs.
  - At offset=15, offset<=0 and go to DONE.
- DONE (1 cycle):
  - ack[cur]=1; pending[cur]<=0; drawn[cur]<=1.
  - Go to SELECT if pending has other bits set; else go to IDLE.
- Outputs are decoded from registered state, offset and cur. A pixel is valid in the same cycle plot=1.
- vga_x, vga_y and vga_colour hold their last values when plot=0.
- Coordinate add is 7-bit, wrapping mod 128; no clipping.
- Latency from the tick sampling edge at cycle k:
  - With prior draw: SELECT at k+1, ERASE k+2..k+17, LATCH k+18, DRAW k+19..k+34, ack at k+35 (35 cycles per sprite).
  - First draw (no erase): ack at k+19.
- tick while busy: tick_missed pulses the next cycle. The tick is dropped and pending is unchanged.
- tick in the same cycle as the DONE→IDLE transition is treated as busy, so it is missed.
- req deasserted after snapshot: the sprite is still served this frame. Request bits arriving after the snapshot wait for the next tick.
- Overlapping sprites: later-served sprite pixels overwrite earlier ones. No hazard handling.

Test Plan:
- Reset, then tick with req=2'b01, x0=10, y0=20, c0=3'b100 → no erase; plot=1 for 16 cycles covering (10..13, 20..23) colour 100; ack=2'b01 at k+19; busy low after.
- Second tick, req=01, x0=11, y0=20 → 16 erase pixels at (10..13, 20..23) colour 000, then 16 draw pixels at (11..14, 20..23) colour 100; ack at k+35.
- req=2'b11 with both sprites previously drawn → sprite0 fully erased, drawn and acked before any sprite1 pixel; ack0 at k+35, ack1 at k+70; exactly 64 plot cycles total.
- tick asserted during DRAW → tick_missed pulses 1 cycle later; pending unchanged; exactly one ack per requested sprite.
- x0=126, y0=127 first draw → pixels wrap: x ∈ {126,127,0,1}, y ∈ {127,0,1,2}.
- resetn low mid-ERASE → plot, busy and ack drop immediately; after release, tick with req=01 draws with no erase (drawn cleared).

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// Shared 4x4 box plotter: on each frame tick, erases and redraws every requesting sprite in turn
// through a single VGA adapter pixel port.
module sprite_draw_scheduler #(
  parameter int         NUM_SPRITES = 2,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     tick,
  input  logic [NUM_SPRITES-1:0]   req,
  input  logic [7*NUM_SPRITES-1:0] x_in,
  input  logic [7*NUM_SPRITES-1:0] y_in,
  input  logic [3*NUM_SPRITES-1:0] c_in,
  output logic [6:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     plot,
  output logic [NUM_SPRITES-1:0]   ack,
  output logic                     busy,
  output logic                     tick_missed
);

  localparam int CW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, ERASE, LATCH, DRAW, DONE} state_t;

  state_t                 state;
  logic [NUM_SPRITES-1:0] pending;
  logic [NUM_SPRITES-1:0] drawn;
  logic [3:0]             offset;
  logic [CW-1:0]          cur;
  logic [CW-1:0]          lowest;
  logic [6:0]             old_x [NUM_SPRITES];
  logic [6:0]             old_y [NUM_SPRITES];
  logic [2:0]             col   [NUM_SPRITES];
  logic [6:0]             hold_x;
  logic [6:0]             hold_y;
  logic [2:0]             hold_c;
  logic [NUM_SPRITES-1:0] cur_mask;
  logic [NUM_SPRITES-1:0] rest;
  logic [6:0]             pix_x;
  logic [6:0]             pix_y;
  logic [2:0]             pix_c;

  always_comb begin
    lowest = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (pending[i]) lowest = CW'(i);
    end
  end

  assign cur_mask = NUM_SPRITES'(1) << cur;
  assign rest     = pending & ~cur_mask;

  // Coordinate add wraps mod 128; ERASE and DRAW share the same base registers.
  assign pix_x = old_x[cur] + {5'b0, offset[1:0]};
  assign pix_y = old_y[cur] + {5'b0, offset[3:2]};
  assign pix_c = (state == ERASE) ? BG_COLOUR : col[cur];

  assign plot       = (state == ERASE) || (state == DRAW);
  assign vga_x      = plot ? pix_x : hold_x;
  assign vga_y      = plot ? pix_y : hold_y;
  assign vga_colour = plot ? pix_c : hold_c;
  assign ack        = (state == DONE) ? cur_mask : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      pending     <= '0;
      drawn       <= '0;
      offset      <= '0;
      cur         <= '0;
      hold_x      <= '0;
      hold_y      <= '0;
      hold_c      <= '0;
      tick_missed <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        old_x[i] <= '0;
        old_y[i] <= '0;
        col[i]   <= '0;
      end
    end else begin
      tick_missed <= tick && (state != IDLE);
      if (plot) begin
        hold_x <= pix_x;
        hold_y <= pix_y;
        hold_c <= pix_c;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            pending <= req;
            if (req != '0) state <= SELECT;
          end
        end
        SELECT: begin
          cur    <= lowest;
          offset <= '0;
          state  <= drawn[lowest] ? ERASE : LATCH;
        end
        ERASE: begin
          offset <= offset + 4'd1;
          if (offset == 4'd15) state <= LATCH;
        end
        LATCH: begin
          old_x[cur] <= x_in[32'(cur)*7 +: 7];
          old_y[cur] <= y_in[32'(cur)*7 +: 7];
          col[cur]   <= c_in[32'(cur)*3 +: 3];
          state      <= DRAW;
        end
        DRAW: begin
          offset <= offset + 4'd1;
          if (offset == 4'd15) state <= DONE;
        end
        DONE: begin
          pending <= rest;
          drawn   <= drawn | cur_mask;
          state   <= (rest != '0) ? SELECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler: pixel streams, ack latency, dropped ticks, wrap and reset abort.
module tb_sprite_draw_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  req = '0;
  logic [13:0] x_in = '0;
  logic [13:0] y_in = '0;
  logic [5:0]  c_in = '0;
  logic [6:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic [1:0]  ack;
  logic        busy;
  logic        tick_missed;

  sprite_draw_scheduler #(.NUM_SPRITES(2), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .req(req),
    .x_in(x_in), .y_in(y_in), .c_in(c_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .ack(ack), .busy(busy), .tick_missed(tick_missed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int got_pix[$];
  int exp_pix[$];
  int ack_cyc[2];
  int ack_cnt, missed_cnt, missed_cyc, first_plot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, want);
    end
  endtask

  function automatic void add_box(input int bx, input int by, input int c);
    for (int off = 0; off < 16; off++)
      exp_pix.push_back((((bx + off % 4) % 128) << 10) | (((by + off / 4) % 128) << 3) | c);
  endfunction

  task automatic set_sprite(input int i, input int x, input int y, input int c);
    x_in[7*i +: 7] = 7'(x);
    y_in[7*i +: 7] = 7'(y);
    c_in[3*i +: 3] = 3'(c);
  endtask

  // Tick is sampled at edge k; returns at the negedge inside cycle k+1.
  task automatic frame_start(input logic [1:0] r);
    tick = 1'b1;
    req  = r;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Observes cycles k+1..k+ncyc; optionally raises tick during cycle inj.
  task automatic watch(input int ncyc, input int inj);
    got_pix.delete();
    ack_cyc[0] = 0; ack_cyc[1] = 0;
    ack_cnt = 0; missed_cnt = 0; missed_cyc = 0; first_plot = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (plot) begin
        got_pix.push_back(int'({vga_x, vga_y, vga_colour}));
        if (first_plot == 0) first_plot = cyc;
      end
      if (ack != '0) begin
        ack_cnt++;
        for (int i = 0; i < 2; i++) if (ack[i]) ack_cyc[i] = cyc;
      end
      if (tick_missed) begin
        missed_cnt++;
        missed_cyc = cyc;
      end
      tick = (cyc == inj);
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic check_pixels(input string tag);
    check({tag, "_npix"}, got_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++)
      check({tag, "_pix"}, got_pix[i], exp_pix[i]);
    exp_pix.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_vga", {vga_x, vga_y, vga_colour}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Without a tick, req alone starts nothing.
    req = 2'b01;
    repeat (3) @(negedge clk);
    check("no_tick_busy", busy, 0);

    // First draw of sprite 0: no erase.
    set_sprite(0, 10, 20, 3'b100);
    frame_start(2'b01);
    watch(25, 0);
    add_box(10, 20, 3'b100);
    check_pixels("t1");
    check("t1_first_plot", first_plot, 3);
    check("t1_ack0", ack_cyc[0], 19);
    check("t1_ack_cnt", ack_cnt, 1);
    check("t1_busy", busy, 0);

    // Move by one: erase old box, draw new.
    set_sprite(0, 11, 20, 3'b100);
    frame_start(2'b01);
    watch(40, 0);
    add_box(10, 20, 3'b000);
    add_box(11, 20, 3'b100);
    check_pixels("t2");
    check("t2_first_plot", first_plot, 2);
    check("t2_ack0", ack_cyc[0], 35);
    check("t2_hold", {vga_x, vga_y, vga_colour}, {7'd14, 7'd23, 3'b100});

    // First draw of sprite 1.
    set_sprite(1, 50, 60, 3'b010);
    frame_start(2'b10);
    watch(25, 0);
    add_box(50, 60, 3'b010);
    check_pixels("t3a");
    check("t3a_ack1", ack_cyc[1], 19);

    // Both drawn, both requested: served in index order.
    set_sprite(0, 20, 30, 3'b001);
    set_sprite(1, 51, 61, 3'b011);
    frame_start(2'b11);
    watch(75, 0);
    add_box(11, 20, 3'b000);
    add_box(20, 30, 3'b001);
    add_box(50, 60, 3'b000);
    add_box(51, 61, 3'b011);
    check_pixels("t3");
    check("t3_ack0", ack_cyc[0], 35);
    check("t3_ack1", ack_cyc[1], 70);
    check("t3_ack_cnt", ack_cnt, 2);

    // Tick during DRAW is dropped; late request for sprite 1 is not served.
    set_sprite(0, 21, 30, 3'b101);
    frame_start(2'b01);
    req = 2'b11;
    watch(45, 25);
    add_box(20, 30, 3'b000);
    add_box(21, 30, 3'b101);
    check_pixels("t4");
    check("t4_missed_cnt", missed_cnt, 1);
    check("t4_missed_cyc", missed_cyc, 26);
    check("t4_ack_cnt", ack_cnt, 1);
    check("t4_ack0", ack_cyc[0], 35);
    check("t4_busy", busy, 0);
    req = 2'b00;

    // Reset in the middle of an erase aborts at once.
    set_sprite(0, 40, 40, 3'b110);
    frame_start(2'b01);
    repeat (4) @(negedge clk);
    check("t6_pre_plot", plot, 1);
    resetn = 1'b0;
    #1;
    check("t6_plot", plot, 0);
    check("t6_busy", busy, 0);
    check("t6_ack", ack, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // After reset: first draw again (no erase), wrapping coordinates, tick on DONE is missed.
    set_sprite(0, 126, 127, 3'b111);
    frame_start(2'b01);
    watch(30, 19);
    add_box(126, 127, 3'b111);
    check_pixels("t5");
    check("t5_first_plot", first_plot, 3);
    check("t5_ack0", ack_cyc[0], 19);
    check("t5_ack_cnt", ack_cnt, 1);
    check("t5_missed", missed_cnt, 1);
    check("t5_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
